periph_data_rr_arbiter: RTL and testbench
=========================================

Name: periph_data_rr_arbiter

Overview:
- Round-robin arbiter that shares one cluster-peripheral slave port between NB_MASTERS core data ports.
- Both sides use the core data req/rsp protocol (core_data_req_t / core_data_rsp_t): req/gnt handshake, then in-order r_valid at least one cycle after gnt.
- An in-order ID FIFO tracks up to MAX_OUTSTANDING granted transactions and routes each response back to the master that issued it.
- Sits between the cores' peripheral data ports and the peripheral interconnect slave plug.

Parameters:
- NB_MASTERS, 4, number of requesting core data ports (≥2).
- MAX_OUTSTANDING, 2, depth of the response-routing ID FIFO (≥1).
- IDW, $clog2(NB_MASTERS), width of the master index (derived, not overridable).

Ports:
- clk_i  in  1  cluster clock.
- rst_i  in  1  reset; synchronous to clk_i, active-high.
- mst_req_i  in  NB_MASTERS x 70  per-master core_data_req_t {req, add[31:0], wen, data[31:0], be[3:0]}.
- mst_rsp_o  out  NB_MASTERS x 34  per-master core_data_rsp_t {gnt, r_data[31:0], r_valid}.
- slv_req_o  out  70  core_data_req_t to the peripheral.
- slv_rsp_i  in  34  core_data_rsp_t from the peripheral.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current ID FIFO occupancy.
- busy_o  out  1  outstanding_o != 0 or lock active.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst_i=1 at a clk_i edge) sets: rr_ptr=0, FIFO rd/wr pointers and count=0, lock=0, err_o=0. Outputs are then outstanding_o=0, busy_o=0, all gnt/r_valid=0, slv_req_o.req=0.
- A reset asserted mid-transaction drops all tracking. Late slave r_valid pulses after reset count as spurious (see err_o).
- full = (count == MAX_OUTSTANDING), registered count only. A pop in the same cycle does NOT unblock; there is no combinational path from r_valid to req.
- Selection (combinational):
  - If lock=1, sel=lock_id.
  - Otherwise sel = first requesting master searching rr_ptr, rr_ptr+1, ..., wrapping mod NB_MASTERS.
- Request path:
  - slv_req_o.req = any_req & ~full.
  - add/wen/data/be are muxed from mst_req_i[sel]. All-zero when no request is selected.
- Grant path:
  - mst_rsp_o[sel].gnt = slv_rsp_i.gnt & slv_req_o.req.
  - gnt=0 for every other master.
- Handshake (slv_req_o.req & slv_rsp_i.gnt at an edge):
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod NB_MASTERS.
  - lock <= 0.
- Stall (slv_req_o.req & ~slv_rsp_i.gnt):
  - lock <= 1, lock_id <= sel.
  - Selection is held until gnt, so payload fields stay stable toward the slave.
  - If the locked master deasserts req (master protocol violation), lock clears at the next edge with no push.
- Response path:
  - slv_rsp_i.r_valid with count>0 pops the FIFO head h.
  - mst_rsp_o[h].r_valid=1; r_valid=0 for all other masters.
  - r_data is broadcast to all masters and qualified by r_valid.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap mod MAX_OUTSTANDING.
- Same-cycle response: an entry pushed at edge N can be popped no earlier than edge N+1. The slave guarantees r_valid ≥1 cycle after gnt.
- Spurious r_valid (count==0): ignored, nothing forwarded, err_o <= 1. err_o clears only on rst_i.
- Latency: zero-cycle combinational request/grant pass-through; zero-cycle response pass-through.

Test Plan:
- Single master: master 0 writes add=0x1000_2000, data=0xA5A5A5A5, be=0xF; slave gnt=1 in cycle 0, r_valid in cycle 1 → mst_rsp_o[0].gnt=1 in cycle 0, mst_rsp_o[0].r_valid=1 in cycle 1, all other masters' gnt and r_valid stay 0, outstanding_o 1→0.
- Fairness: all 4 masters hold req, slave gnt=1 and r_valid=1 every cycle after the first → grant order 0,1,2,3,0,1,… with no master skipped.
- Stall lock: masters 1 and 2 request and slave holds gnt=0 for 3 cycles → sel=1 for all 3 cycles, slv_req_o fields equal master 1's fields, grant goes to 1 on cycle 4, then to 2.
- Backpressure: MAX_OUTSTANDING=2, slave gnt always 1, r_valid delayed 4 cycles → after 2 grants slv_req_o.req=0 and outstanding_o=2. Requests resume only at the cycle after the first r_valid.
- Response routing: grant master 2 then master 0; responses r_data=0xDEADBEEF then 0x12345678 → master 2 gets r_valid with 0xDEADBEEF, then master 0 gets r_valid with 0x12345678.
- Errors and reset: r_valid with FIFO empty → err_o=1 and stays 1. Assert rst_i with 2 outstanding → next cycle outstanding_o=0, err_o=0, rr_ptr=0.

Source files
------------

// File: rtl/periph_data_rr_arbiter.sv
// ============================================================================
//  Module   : periph_data_rr_arbiter
//  Brief    : Round-robin arbiter sharing one peripheral data port between
//             NB_MASTERS core data ports, with in-order response routing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_data_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic [31:0] r_data;
        logic        r_valid;
    } core_data_rsp_t;
endpackage

module periph_data_rr_arbiter
    import core_data_pkg::*;
#(
    parameter  int NB_MASTERS      = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int IDW             = $clog2(NB_MASTERS),
    localparam int CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  core_data_req_t [NB_MASTERS-1:0] mst_req_i,
    output core_data_rsp_t [NB_MASTERS-1:0] mst_rsp_o,
    output core_data_req_t                  slv_req_o,
    input  core_data_rsp_t                  slv_rsp_i,
    output logic [CNTW-1:0]                 outstanding_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int             PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [IDW:0]   NB_W = (IDW + 1)'(NB_MASTERS);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IDW-1:0]  lock_id_q, lock_id_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            err_q, err_d;
    logic [IDW-1:0]  fifo_q [MAX_OUTSTANDING];

    logic            w_any_req;
    logic [IDW-1:0]  w_sel;
    logic            w_full;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic [IDW-1:0]  w_head;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // While locked the stalled master owns the port; otherwise search from rr_ptr.
    always_comb begin
        logic [IDW:0] idx;
        w_any_req = 1'b0;
        w_sel     = '0;
        idx       = '0;
        if (lock_q) begin
            w_sel     = lock_id_q;
            w_any_req = mst_req_i[lock_id_q].req;
        end else begin
            for (int i = NB_MASTERS - 1; i >= 0; i--) begin
                idx = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
                if (idx >= NB_W) begin
                    idx = idx - NB_W;
                end
                if (mst_req_i[idx[IDW-1:0]].req) begin
                    w_any_req = 1'b1;
                    w_sel     = idx[IDW-1:0];
                end
            end
        end
    end

    assign w_full = (count_q == CNTW'(MAX_OUTSTANDING));
    assign w_req  = w_any_req & ~w_full;
    assign w_push = w_req & slv_rsp_i.gnt;
    assign w_pop  = slv_rsp_i.r_valid & (count_q != '0);
    assign w_head = fifo_q[rd_ptr_q];

    always_comb begin
        slv_req_o = '0;
        if (w_any_req) begin
            slv_req_o = mst_req_i[w_sel];
        end
        slv_req_o.req = w_req;
    end

    always_comb begin
        for (int i = 0; i < NB_MASTERS; i++) begin
            mst_rsp_o[i].gnt     = w_push & (w_sel == IDW'(i));
            mst_rsp_o[i].r_data  = slv_rsp_i.r_data;
            mst_rsp_o[i].r_valid = w_pop & (w_head == IDW'(i));
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;

        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rr_ptr_d = (w_sel == IDW'(NB_MASTERS - 1)) ? '0 : w_sel + IDW'(1);
            lock_d   = 1'b0;
        end else if (w_req) begin
            lock_d    = 1'b1;
            lock_id_d = w_sel;
        end else if (lock_q && !mst_req_i[lock_id_q].req) begin
            // Locked master withdrew its request: release without a transfer.
            lock_d = 1'b0;
        end

        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (w_push && !w_pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNTW'(1);
        end

        if (slv_rsp_i.r_valid && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_sel;
        end
    end

    assign outstanding_o = count_q;
    assign busy_o        = (count_q != '0) | lock_q;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_periph_data_rr_arbiter.sv
// ============================================================================
//  Module   : tb_periph_data_rr_arbiter
//  Brief    : Directed vector table plus hand sequences for the RR arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_data_rr_arbiter;
    import core_data_pkg::*;

    localparam int NB = 4;

    logic                    clk = 1'b0;
    logic                    rst_i;
    core_data_req_t [NB-1:0] mst_req_i;
    core_data_rsp_t [NB-1:0] mst_rsp_o;
    core_data_req_t          slv_req_o;
    core_data_rsp_t          slv_rsp_i;
    logic [1:0]              outstanding_o;
    logic                    busy_o;
    logic                    err_o;

    int n_checks = 0;
    int n_errors = 0;

    periph_data_rr_arbiter #(
        .NB_MASTERS      (NB),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mst_req_i     (mst_req_i),
        .mst_rsp_o     (mst_rsp_o),
        .slv_req_o     (slv_req_o),
        .slv_rsp_i     (slv_rsp_i),
        .outstanding_o (outstanding_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        int          e_sel;
        logic [3:0]  e_gnt;
        logic [3:0]  e_rv;
        int          e_out;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [31:0] m_add(input int i);
        return 32'h1000_0000 | (32'(i) << 8);
    endfunction

    function automatic logic [31:0] m_data(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic vec_t mkv(input logic [3:0] req, input logic g, input logic rv,
                                 input logic [31:0] rd, input logic ereq, input int esel,
                                 input logic [3:0] egnt, input logic [3:0] erv,
                                 input int eout, input logic eerr, input logic ebusy);
        vec_t v;
        v.req = req; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_req = ereq; v.e_sel = esel; v.e_gnt = egnt; v.e_rv = erv;
        v.e_out = eout; v.e_err = eerr; v.e_busy = ebusy;
        return v;
    endfunction

    function automatic logic [3:0] gnt_mask();
        logic [3:0] m;
        for (int i = 0; i < NB; i++) m[i] = mst_rsp_o[i].gnt;
        return m;
    endfunction

    function automatic logic [3:0] rv_mask();
        logic [3:0] m;
        for (int i = 0; i < NB; i++) m[i] = mst_rsp_o[i].r_valid;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic g, input logic rv, input logic [31:0] rd);
        for (int i = 0; i < NB; i++) begin
            mst_req_i[i].req  = req[i];
            mst_req_i[i].add  = m_add(i);
            mst_req_i[i].wen  = i[0];
            mst_req_i[i].data = m_data(i);
            mst_req_i[i].be   = 4'hF ^ 4'(i);
        end
        slv_rsp_i.gnt     = g;
        slv_rsp_i.r_valid = rv;
        slv_rsp_i.r_data  = rd;
    endtask

    task automatic cyc(input logic [3:0] req, input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        drive(req, g, rv, rd);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        drive(4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(4'h0, 1'b0, 1'b0, 32'h0);

        // fairness, stall lock, backpressure, drain and spurious response
        tbl[0]  = mkv(4'hF, 1, 0, 32'hD000_0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 0);
        tbl[1]  = mkv(4'hF, 1, 1, 32'hD000_0001, 1, 1, 4'b0010, 4'b0001, 1, 0, 1);
        tbl[2]  = mkv(4'hF, 1, 1, 32'hD000_0002, 1, 2, 4'b0100, 4'b0010, 1, 0, 1);
        tbl[3]  = mkv(4'hF, 1, 1, 32'hD000_0003, 1, 3, 4'b1000, 4'b0100, 1, 0, 1);
        tbl[4]  = mkv(4'hF, 1, 1, 32'hD000_0004, 1, 0, 4'b0001, 4'b1000, 1, 0, 1);
        tbl[5]  = mkv(4'h0, 0, 1, 32'hD000_0005, 0, 0, 4'b0000, 4'b0001, 1, 0, 1);
        tbl[6]  = mkv(4'h6, 0, 0, 32'h0,         1, 1, 4'b0000, 4'b0000, 0, 0, 0);
        tbl[7]  = mkv(4'h6, 0, 0, 32'h0,         1, 1, 4'b0000, 4'b0000, 0, 0, 1);
        tbl[8]  = mkv(4'h6, 0, 0, 32'h0,         1, 1, 4'b0000, 4'b0000, 0, 0, 1);
        tbl[9]  = mkv(4'h6, 1, 0, 32'h0,         1, 1, 4'b0010, 4'b0000, 0, 0, 1);
        tbl[10] = mkv(4'h4, 1, 1, 32'hD000_000A, 1, 2, 4'b0100, 4'b0010, 1, 0, 1);
        tbl[11] = mkv(4'hF, 1, 0, 32'h0,         1, 3, 4'b1000, 4'b0000, 1, 0, 1);
        tbl[12] = mkv(4'hF, 1, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2, 0, 1);
        tbl[13] = mkv(4'hF, 1, 1, 32'hD000_000D, 0, 0, 4'b0000, 4'b0100, 2, 0, 1);
        tbl[14] = mkv(4'hF, 1, 0, 32'h0,         1, 0, 4'b0001, 4'b0000, 1, 0, 1);
        tbl[15] = mkv(4'h0, 0, 1, 32'hD000_000F, 0, 0, 4'b0000, 4'b1000, 2, 0, 1);
        tbl[16] = mkv(4'h0, 0, 1, 32'hD000_0010, 0, 0, 4'b0000, 4'b0001, 1, 0, 1);
        tbl[17] = mkv(4'h0, 0, 1, 32'hD000_0011, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        tbl[18] = mkv(4'h0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 0, 1, 0);

        // reset state
        do_reset();
        chk("rst_out",  64'(outstanding_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_err",  64'(err_o), 0);
        chk("rst_req",  64'(slv_req_o.req), 0);
        chk("rst_gnt",  64'(gnt_mask()), 0);
        chk("rst_rv",   64'(rv_mask()), 0);

        for (int k = 0; k < 19; k++) begin
            cyc(tbl[k].req, tbl[k].gnt, tbl[k].rv, tbl[k].rdata);
            chk($sformatf("v%0d_req", k),  64'(slv_req_o.req), 64'(tbl[k].e_req));
            chk($sformatf("v%0d_gnt", k),  64'(gnt_mask()), 64'(tbl[k].e_gnt));
            chk($sformatf("v%0d_rv", k),   64'(rv_mask()), 64'(tbl[k].e_rv));
            chk($sformatf("v%0d_out", k),  64'(outstanding_o), 64'(tbl[k].e_out));
            chk($sformatf("v%0d_err", k),  64'(err_o), 64'(tbl[k].e_err));
            chk($sformatf("v%0d_busy", k), 64'(busy_o), 64'(tbl[k].e_busy));
            if (tbl[k].e_req) begin
                chk($sformatf("v%0d_add", k),  64'(slv_req_o.add),  64'(m_add(tbl[k].e_sel)));
                chk($sformatf("v%0d_data", k), 64'(slv_req_o.data), 64'(m_data(tbl[k].e_sel)));
            end
            if (tbl[k].rv) begin
                chk($sformatf("v%0d_rdata", k), 64'(mst_rsp_o[0].r_data), 64'(tbl[k].rdata));
            end
        end

        // single master write with custom payload
        do_reset();
        @(negedge clk);
        drive(4'h1, 1'b1, 1'b0, 32'h0);
        mst_req_i[0].add  = 32'h1000_2000;
        mst_req_i[0].data = 32'hA5A5_A5A5;
        mst_req_i[0].be   = 4'hF;
        mst_req_i[0].wen  = 1'b1;
        #1;
        chk("sm_gnt",  64'(gnt_mask()), 64'b0001);
        chk("sm_add",  64'(slv_req_o.add), 64'h1000_2000);
        chk("sm_data", 64'(slv_req_o.data), 64'hA5A5_A5A5);
        chk("sm_be",   64'(slv_req_o.be), 64'hF);
        chk("sm_out0", 64'(outstanding_o), 0);
        cyc(4'h0, 1'b0, 1'b1, 32'h0000_0042);
        chk("sm_rv",   64'(rv_mask()), 64'b0001);
        chk("sm_gnt1", 64'(gnt_mask()), 0);
        chk("sm_out1", 64'(outstanding_o), 1);
        cyc(4'h0, 1'b0, 1'b0, 32'h0);
        chk("sm_out2", 64'(outstanding_o), 0);

        // response routing: master 2 then master 0
        do_reset();
        cyc(4'h4, 1'b1, 1'b0, 32'h0);
        chk("rt_g2", 64'(gnt_mask()), 64'b0100);
        cyc(4'h1, 1'b1, 1'b0, 32'h0);
        chk("rt_g0", 64'(gnt_mask()), 64'b0001);
        cyc(4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("rt_rv2", 64'(rv_mask()), 64'b0100);
        chk("rt_d2",  64'(mst_rsp_o[2].r_data), 64'hDEAD_BEEF);
        chk("rt_o2",  64'(outstanding_o), 2);
        cyc(4'h0, 1'b0, 1'b1, 32'h1234_5678);
        chk("rt_rv0", 64'(rv_mask()), 64'b0001);
        chk("rt_d0",  64'(mst_rsp_o[0].r_data), 64'h1234_5678);
        cyc(4'h0, 1'b0, 1'b0, 32'h0);
        chk("rt_o0", 64'(outstanding_o), 0);

        // sticky error, then reset with two outstanding
        do_reset();
        cyc(4'h0, 1'b0, 1'b1, 32'h0);
        chk("er_rv", 64'(rv_mask()), 0);
        cyc(4'h0, 1'b0, 1'b0, 32'h0);
        chk("er_set", 64'(err_o), 1);
        cyc(4'h3, 1'b1, 1'b0, 32'h0);
        chk("er_sticky", 64'(err_o), 1);
        chk("er_g0", 64'(gnt_mask()), 64'b0001);
        cyc(4'h3, 1'b1, 1'b0, 32'h0);
        chk("er_g1", 64'(gnt_mask()), 64'b0010);
        cyc(4'h0, 1'b0, 1'b0, 32'h0);
        chk("er_o2", 64'(outstanding_o), 2);
        do_reset();
        chk("mr_out",  64'(outstanding_o), 0);
        chk("mr_err",  64'(err_o), 0);
        chk("mr_busy", 64'(busy_o), 0);
        cyc(4'hF, 1'b0, 1'b0, 32'h0);
        chk("mr_req", 64'(slv_req_o.req), 1);
        chk("mr_rr0", 64'(slv_req_o.add), 64'(m_add(0)));
        cyc(4'h0, 1'b0, 1'b1, 32'h0);
        chk("mr_late_rv", 64'(rv_mask()), 0);
        cyc(4'h0, 1'b0, 1'b0, 32'h0);
        chk("mr_late_err", 64'(err_o), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
